pacman_status: RTL and testbench
================================

# pacman_status

Game-status tracker that drives the `over`/`win` inputs of the top-level game FSM and obeys its `reseton` restart pulse. It counts remaining pellets, remaining lives, score, post-hit grace time and power-pellet fright time from one-cycle gameplay event pulses. It raises sticky `over` or `win` when the round ends. It sits between the sprite/collision logic and the game FSM.

## Interface
- `NUM_PELLETS`, 150: pellets per maze, 1..255
- `LIVES`, 3: starting lives, 1..3
- `GRACE_FRAMES`, 120: invulnerable frames after losing a life, 1..511
- `FRIGHT_FRAMES`, 360: frames of fright after a power pellet, 1..511
- `PELLET_PTS`, 10: score per normal pellet
- `POWER_PTS`, 50: score per power pellet
- `GHOST_PTS`, 200: score per ghost eaten in fright

- `Clk` input 1: system clock
- `Reset` input 1: synchronous, active-high
- `reseton` input 1: restart pulse from the game FSM; same effect as `Reset`
- `frame_tick` input 1: one-cycle pulse per video frame (vsync)
- `pellet_eaten` input 1: one-cycle pulse, normal pellet consumed
- `power_eaten` input 1: one-cycle pulse, power pellet consumed
- `ghost_hit` input 1: one-cycle pulse, Pac-Man/ghost collision
- `over` output 1: game lost; sticky
- `win` output 1: all pellets eaten; sticky
- `lives` output 2: remaining lives
- `score` output 16: binary score, saturating
- `pellets_left` output 8: remaining pellets
- `grace` output 1: high while in GRACE
- `fright` output 1: high while the fright timer is nonzero

## Operation
- States: PLAY, GRACE, WON, LOST.
- On `Reset` or `reseton`:
  - state PLAY, `lives`=LIVES, `pellets_left`=NUM_PELLETS, `score`=0
  - both timers 0; `over`=`win`=`grace`=`fright`=0
- Pellet event, in PLAY or GRACE (`pellet_eaten` | `power_eaten`):
  - `pellets_left` decrements by exactly one.
  - If both inputs are asserted in the same cycle, it counts as one power pellet.
  - Score adds POWER_PTS for a power pellet, otherwise PELLET_PTS.
  - If `pellets_left` was 1, the next state is WON.
- `power_eaten`: loads the fright timer with FRIGHT_FRAMES, retriggering if already running.
- `ghost_hit` in PLAY with `fright`=1: score += GHOST_PTS; no life lost.
- `ghost_hit` in PLAY with `fright`=0:
  - `lives` decrements.
  - If `lives` was 1, the next state is LOST.
  - Otherwise the next state is GRACE and the grace timer loads GRACE_FRAMES.
- `ghost_hit` in GRACE: ignored.
- GRACE: the grace timer decrements on `frame_tick`; at 0 the state returns to PLAY.
- WON/LOST: all event inputs are ignored. `win` (WON) or `over` (LOST) holds until `Reset`/`reseton`. The fright timer is cleared.
- Simultaneous pellet-completing event and lethal `ghost_hit`: WON takes priority.
- Score: 17-bit add, clamped to 16'hFFFF.

## Timing
- All outputs are registered.
- Event effects are visible in the cycle after the pulse.
- `over`/`win` assert one cycle after the fatal or last-pellet pulse.
- `frame_tick` in the same cycle as a timer load: the load wins, with no decrement that cycle.
- A timer at 0 does not underflow.
- `fright` deasserts in the cycle after the timer reaches 0.
- `reseton` mid-GRACE or mid-fright: all state is restored to reset values in the next cycle.

## Configuration
- `PACMAN_POWER_PELLET_EN` defined:
  - Fright timer and ghost-eating behave as above.
- Undefined:
  - `power_eaten` is treated as an ordinary pellet worth PELLET_PTS.
  - `fright` is tied 0; no fright timer logic.
  - `ghost_hit` outside GRACE always costs a life.

## Structure
- `pacman_pkg` holds:
  - the state enum (PLAY, GRACE, WON, LOST)
  - the points constants
  - the frame-timer width (9)
- Sub-module `frame_timer`: loadable down-counter with `load`, `load_val`, `frame_tick` and `zero`. It is instantiated twice, for grace and for fright.

## Test plan
- Reset, then 150 `pellet_eaten` pulses: `pellets_left`=0, `score`=1500, `win`=1 one cycle after the last pulse; it stays 1 until `reseton`.
- 3 `ghost_hit` pulses, each after its grace expires (120 `frame_tick`s): `lives` steps 2, 1, 0; `over`=1 after the third pulse; `grace`=1 for exactly 120 ticks after hits 1 and 2.
- `ghost_hit` at GRACE tick 60: `lives` unchanged.
- `power_eaten`, then `ghost_hit` 10 frames later: `score`=50+200, `lives`=3.
- `power_eaten` again at frame 300: `fright` stays 1 for a further 360 frames.
- `pellets_left`=1 with last `pellet_eaten` and `ghost_hit` together at `lives`=1: `win`=1, `over`=0.
- `reseton` pulse while in LOST with fright active: next cycle `lives`=3, `score`=0, `pellets_left`=150, all flags 0.
- Without `PACMAN_POWER_PELLET_EN`: `power_eaten` then `ghost_hit` gives `score`=10 and `lives`=2.

Source files
------------

// File: rtl/pacman_pkg.sv
// pacman_pkg: shared types and constants for the Pac-Man game-status tracker.
//   game_state_e : round state (play, post-hit grace, won, lost)
//   TimerWidth   : width of the frame-based grace and fright down-counters
//   *Pts         : default score values for pellets, power pellets and ghosts
//   sat_add16    : 16-bit score add that clamps at 16'hFFFF
package pacman_pkg;

    typedef enum logic [1:0] {
        StPlay,
        StGrace,
        StWon,
        StLost
    } game_state_e;

    localparam int unsigned TimerWidth = 9;

    localparam int unsigned PelletPts = 10;
    localparam int unsigned PowerPts  = 50;
    localparam int unsigned GhostPts  = 200;

    // The increment can carry pellet plus ghost points in one cycle, so it is
    // wider than the score; the sum gets one more bit so it never wraps.
    function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [17:0] inc);
        logic [18:0] sum;
        sum = {3'b000, base} + {1'b0, inc};
        return (sum > 19'h0FFFF) ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter clocked by video-frame pulses.
//   Clk        : system clock
//   clr        : synchronous clear to zero (highest priority)
//   load       : load load_val this cycle; wins over a coincident frame_tick
//   load_val   : value to load
//   frame_tick : one-cycle pulse per frame; decrements a nonzero count
//   zero       : count is zero (decoded straight from the count register)
module frame_timer
    import pacman_pkg::*;
(
    input  logic                  Clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [TimerWidth-1:0] load_val,
    input  logic                  frame_tick,
    output logic                  zero
);

    logic [TimerWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (frame_tick && (cnt_q != '0)) begin
            // Holds at zero rather than wrapping.
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pacman_status.sv
// pacman_status: game-status tracker between the sprite/collision logic and
// the top-level game FSM. Counts pellets, lives and score, runs the post-hit
// grace timer and (optionally) the power-pellet fright timer, and raises
// sticky over/win when the round ends.
//
// Build option: define PACMAN_POWER_PELLET_EN to enable power pellets (fright
// timer, ghost eating). Without it power_eaten is an ordinary pellet, fright
// is tied low and every ghost_hit outside grace costs a life.
//
// Ports:
//   Clk          : system clock
//   Reset        : synchronous, active-high reset
//   reseton      : restart pulse from the game FSM, same effect as Reset
//   frame_tick   : one pulse per video frame
//   pellet_eaten : normal pellet consumed (pulse)
//   power_eaten  : power pellet consumed (pulse)
//   ghost_hit    : Pac-Man/ghost collision (pulse)
//   over         : game lost, sticky until restart
//   win          : all pellets eaten, sticky until restart
//   lives        : remaining lives
//   score        : saturating binary score
//   pellets_left : remaining pellets
//   grace        : high while in post-hit grace
//   fright       : high while the fright timer is nonzero
module pacman_status
    import pacman_pkg::*;
#(
    parameter int unsigned NUM_PELLETS   = 150,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned GRACE_FRAMES  = 120,
    parameter int unsigned FRIGHT_FRAMES = 360,
    parameter int unsigned PELLET_PTS    = PelletPts,
    parameter int unsigned POWER_PTS     = PowerPts,
    parameter int unsigned GHOST_PTS     = GhostPts
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        reseton,
    input  logic        frame_tick,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic        ghost_hit,
    output logic        over,
    output logic        win,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [7:0]  pellets_left,
    output logic        grace,
    output logic        fright
);

    game_state_e state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  pellets_q, pellets_d;
    logic [15:0] score_q, score_d;
    logic        over_q, win_q, grace_q;

    logic        restart;
    logic        active;
    logic        pellet_ev;
    logic        power_ev;
    logic        hit;
    logic        lethal;
    logic        frightened;
    logic        last_pellet;
    logic        terminal_d;
    logic        timer_clr;
    logic        grace_load;
    logic        grace_zero;
    logic [17:0] add;

    assign restart   = Reset | reseton;
    assign active    = (state_q == StPlay) || (state_q == StGrace);
    // Pellet and power pellet together still remove only one pellet.
    assign pellet_ev = active & (pellet_eaten | power_eaten);
    assign hit       = ghost_hit && (state_q == StPlay);
    assign lethal    = hit && !frightened;

`ifdef PACMAN_POWER_PELLET_EN
    logic fright_zero;

    assign power_ev   = pellet_ev & power_eaten;
    assign frightened = ~fright_zero;

    frame_timer u_fright_timer (
        .Clk        (Clk),
        .clr        (timer_clr),
        .load       (power_ev),
        .load_val   (TimerWidth'(FRIGHT_FRAMES)),
        .frame_tick (frame_tick),
        .zero       (fright_zero)
    );
`else
    assign power_ev   = 1'b0;
    assign frightened = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        pellets_d   = pellets_q;
        add         = '0;
        grace_load  = 1'b0;
        last_pellet = 1'b0;

        if (pellet_ev) begin
            pellets_d   = pellets_q - 8'd1;
            add         = power_ev ? 18'(POWER_PTS) : 18'(PELLET_PTS);
            last_pellet = (pellets_q == 8'd1);
        end

        if (hit && frightened) begin
            add = add + 18'(GHOST_PTS);
        end

        // Clearing the maze beats a simultaneous lethal hit; that hit then
        // costs nothing.
        if (last_pellet) begin
            state_d = StWon;
        end else if (lethal) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
                state_d = StLost;
            end else begin
                state_d    = StGrace;
                grace_load = 1'b1;
            end
        end else if ((state_q == StGrace) && grace_zero) begin
            state_d = StPlay;
        end

        score_d = sat_add16(score_q, add);

        if (restart) begin
            state_d    = StPlay;
            lives_d    = 2'(LIVES);
            pellets_d  = 8'(NUM_PELLETS);
            score_d    = '0;
            grace_load = 1'b0;
        end
    end

    assign terminal_d = (state_d == StWon) || (state_d == StLost);
    // Timers are flushed on restart and on entering a finished round.
    assign timer_clr  = restart | terminal_d;

    frame_timer u_grace_timer (
        .Clk        (Clk),
        .clr        (timer_clr),
        .load       (grace_load),
        .load_val   (TimerWidth'(GRACE_FRAMES)),
        .frame_tick (frame_tick),
        .zero       (grace_zero)
    );

    always_ff @(posedge Clk) begin
        state_q   <= state_d;
        lives_q   <= lives_d;
        pellets_q <= pellets_d;
        score_q   <= score_d;
        over_q    <= (state_d == StLost);
        win_q     <= (state_d == StWon);
        grace_q   <= (state_d == StGrace);
    end

    assign over         = over_q;
    assign win          = win_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign pellets_left = pellets_q;
    assign grace        = grace_q;
    assign fright       = frightened;

endmodule

// File: tb/tb_pacman_status.sv
// tb_pacman_status: directed scenarios plus randomized play, each cycle
// compared against a behavioural game model kept in plain integers.
module tb_pacman_status;

    localparam int NP = 150;
    localparam int NL = 3;
    localparam int GF = 120;
    localparam int FF = 360;

`ifdef PACMAN_POWER_PELLET_EN
    localparam bit PowerEn = 1'b1;
`else
    localparam bit PowerEn = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        reseton = 1'b0;
    logic        frame_tick = 1'b0;
    logic        pellet_eaten = 1'b0;
    logic        power_eaten = 1'b0;
    logic        ghost_hit = 1'b0;
    logic        over, win, grace, fright;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [7:0]  pellets_left;

    int total = 0;
    int bad   = 0;

    // Model state: plain counts and flags.
    int m_lives, m_pel, m_score, m_grace, m_fright;
    bit m_in_grace, m_won, m_lost;

    always #5 Clk = ~Clk;

    pacman_status dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .reseton      (reseton),
        .frame_tick   (frame_tick),
        .pellet_eaten (pellet_eaten),
        .power_eaten  (power_eaten),
        .ghost_hit    (ghost_hit),
        .over         (over),
        .win          (win),
        .lives        (lives),
        .score        (score),
        .pellets_left (pellets_left),
        .grace        (grace),
        .fright       (fright)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model(input bit rst, input bit pel, input bit pow,
                                  input bit gh, input bit tick);
        int  add;
        bit  fr, done, lethal, is_pow;
        if (rst) begin
            m_lives = NL; m_pel = NP; m_score = 0; m_grace = 0; m_fright = 0;
            m_in_grace = 0; m_won = 0; m_lost = 0;
            return;
        end
        if (m_won || m_lost) return;
        fr = (m_fright > 0);
        is_pow = PowerEn && pow;
        add = 0; done = 0; lethal = 0;
        if (pel || pow) begin
            m_pel--;
            add += is_pow ? 50 : 10;
            done = (m_pel == 0);
        end
        if (gh && !m_in_grace) begin
            if (fr) add += 200;
            else lethal = 1;
        end
        m_score = (m_score + add > 65535) ? 65535 : m_score + add;
        if (is_pow) m_fright = FF;
        else if (tick && m_fright > 0) m_fright--;
        if (done) begin
            m_won = 1; m_in_grace = 0; m_grace = 0; m_fright = 0;
        end else if (lethal) begin
            m_lives--;
            if (m_lives == 0) begin
                m_lost = 1; m_fright = 0;
            end else begin
                m_in_grace = 1; m_grace = GF;
            end
        end else if (m_in_grace) begin
            if (m_grace == 0) m_in_grace = 0;
            else if (tick) m_grace--;
        end
    endfunction

    task automatic check_all();
        check("lives", lives, m_lives);
        check("pellets_left", pellets_left, m_pel);
        check("score", score, m_score);
        check("over", over, m_lost);
        check("win", win, m_won);
        check("grace", grace, m_in_grace);
        check("fright", fright, m_fright > 0);
    endtask

    // One clock: drive, take the edge, advance the model, check away from the edge.
    task automatic step(input bit rst, input bit ron, input bit pel, input bit pow,
                        input bit gh, input bit tick);
        Reset = rst; reseton = ron; pellet_eaten = pel; power_eaten = pow;
        ghost_hit = gh; frame_tick = tick;
        @(posedge Clk);
        model(rst | ron, pel, pow, gh, tick);
        #1;
        Reset = 0; reseton = 0; pellet_eaten = 0; power_eaten = 0;
        ghost_hit = 0; frame_tick = 0;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick_pair();
        step(0, 0, 0, 0, 0, 1);
        idle();
    endtask

    // Ticks every other cycle until grace drops; returns ticks seen while high.
    task automatic run_out_grace(output int ticks);
        ticks = 0;
        for (int i = 0; i < 2 * GF + 20; i++) begin
            if (!grace) break;
            ticks++;
            tick_pair();
        end
    endtask

    initial begin
        int n;

        // Reset state.
        step(1, 0, 0, 0, 0, 0);
        check("rst_lives", lives, 3);
        check("rst_pellets", pellets_left, 150);
        check("rst_flags", {over, win, grace, fright}, 0);

        // Clear the maze with plain pellets.
        repeat (NP - 1) step(0, 0, 1, 0, 0, 0);
        check("win_early", win, 0);
        step(0, 0, 1, 0, 0, 0);
        check("win_last", win, 1);
        check("score_1500", score, 1500);
        check("pellets_0", pellets_left, 0);
        repeat (5) step(0, 0, 1, 1, 1, 1);
        check("win_sticky", win, 1);
        step(0, 1, 0, 0, 0, 0);
        check("win_cleared", win, 0);

        // Three lethal hits, grace length, hit during grace ignored.
        step(0, 0, 0, 0, 1, 0);
        check("hit1_lives", lives, 2);
        run_out_grace(n);
        check("grace_ticks1", n, GF);
        step(0, 0, 0, 0, 1, 0);
        check("hit2_lives", lives, 1);
        repeat (59) tick_pair();
        step(0, 0, 0, 0, 1, 1);
        check("grace_hit_lives", lives, 1);
        idle();
        run_out_grace(n);
        check("grace_ticks2", n, GF - 60);
        step(0, 0, 0, 0, 1, 0);
        check("hit3_lives", lives, 0);
        check("hit3_over", over, 1);
        repeat (4) step(0, 0, 1, 1, 1, 1);
        check("over_sticky", over, 1);

        // Restart from LOST.
        step(0, 1, 0, 0, 0, 0);
        check("ron_lives", lives, 3);
        check("ron_score", score, 0);
        check("ron_pellets", pellets_left, 150);
        check("ron_flags", {over, win, grace, fright}, 0);

        // Power pellet then ghost 10 frames later.
        step(0, 0, 0, 1, 0, 0);
        repeat (10) tick_pair();
        step(0, 0, 0, 0, 1, 0);
        check("power_ghost_score", score, PowerEn ? 250 : 10);
        check("power_ghost_lives", lives, PowerEn ? 3 : 2);
`ifdef PACMAN_POWER_PELLET_EN
        repeat (290) tick_pair();
        step(0, 0, 0, 1, 0, 0);
        repeat (FF - 1) tick_pair();
        check("fright_retrig_hold", fright, 1);
        tick_pair();
        check("fright_retrig_end", fright, 0);
`endif

        // Last pellet and lethal hit together at one life: win wins.
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        run_out_grace(n);
        step(0, 0, 0, 0, 1, 0);
        run_out_grace(n);
        repeat (NP - 1) step(0, 0, 1, 0, 0, 0);
        check("prio_pellets_1", pellets_left, 1);
        step(0, 0, 1, 0, 1, 0);
        check("prio_win", win, 1);
        check("prio_over", over, 0);

        // Randomized play against the model.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8000; i++) begin
            step($urandom_range(0, 799) == 0, $urandom_range(0, 599) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
